rotation_theta_tracker: RTL

- Parametrised successor to the IR-driven angle generator in the POV display.
- Takes the debounced IR index pulse, measures the rotor period, and produces the angular slice index (dtheta) consumed by frame_manager and hub75_output.
- Adds over the single-mark version: multiple index marks per revolution, divider-free DDA slice timing, glitch rejection, stall/timeout detection, a lock status, and a runtime angular offset.

---
 rtl/rotation_theta_tracker.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rotation_theta_tracker.sv
// Rotor angle tracker: measures the IR mark-to-mark period and advances the
// angular slice index with a divider-free DDA between marks.
module rotation_theta_tracker #(
  parameter int ROTATIONAL_RES = 1024,
  parameter int NUM_MARKS      = 1,
  parameter int PERIOD_W       = 24,
  parameter int MIN_PERIOD     = 2048,
  parameter int MAX_PERIOD     = 2**24-1
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              ir_tripped,
  input  logic [$clog2(ROTATIONAL_RES)-1:0] offset_in,
  output logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
  output logic                              theta_valid,
  output logic                              theta_step,
  output logic [PERIOD_W-1:0]               period_out,
  output logic                              locked,
  output logic                              stalled
);
  // state       | meaning
  // ST_UNLOCKED | no period reference; the next edge is always accepted
  // ST_ACQUIRE  | one mark seen, waiting for a second to measure the period
  // ST_LOCKED   | period known, DDA advancing the slice index

  localparam int RES_W  = $clog2(ROTATIONAL_RES);
  localparam int S      = ROTATIONAL_RES / NUM_MARKS;
  localparam int MARK_W = (NUM_MARKS > 1) ? $clog2(NUM_MARKS) : 1;

  localparam logic [RES_W-1:0]    SLICE_LAST = RES_W'(S - 1);
  localparam logic [PERIOD_W:0]   S_ACC      = (PERIOD_W+1)'(S);
  localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] MAX_P      = PERIOD_W'(MAX_PERIOD);
  localparam logic [MARK_W-1:0]   MARK_ONE   = MARK_W'((NUM_MARKS > 1) ? 1 : 0);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED} state_t;

  state_t              state;
  logic                ir_prev;
  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W:0]   acc;
  logic [RES_W-1:0]    slice;
  logic [RES_W-1:0]    offset_lat;
  logic [MARK_W-1:0]   mark;
  logic                adv;

  logic                edge_det;
  logic                accept;
  logic                stall_now;
  logic [PERIOD_W:0]   acc_sum;
  logic [PERIOD_W:0]   period_ext;
  logic [MARK_W-1:0]   mark_inc;
  logic [RES_W-1:0]    theta_calc;

  // A mark outranks both a DDA step and a stall landing on the same cycle.
  always_comb begin
    edge_det   = ir_tripped & ~ir_prev;
    accept     = edge_det & ((state == ST_UNLOCKED) | (count >= MIN_P));
    stall_now  = (state != ST_UNLOCKED) & (count == MAX_P) & ~accept;
    period_ext = {1'b0, period_out};
    acc_sum    = acc + S_ACC;
    mark_inc   = (NUM_MARKS > 1) ? mark + 1'b1 : '0;
    theta_calc = RES_W'(32'(mark) * S) + slice + offset_lat;
  end

  assign theta_valid = locked;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= ST_UNLOCKED;
      ir_prev    <= 1'b0;
      count      <= '0;
      acc        <= '0;
      slice      <= '0;
      offset_lat <= '0;
      mark       <= '0;
      adv        <= 1'b0;
      dtheta     <= '0;
      theta_step <= 1'b0;
      period_out <= '0;
      locked     <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      ir_prev    <= ir_tripped;
      adv        <= 1'b0;
      // dtheta and theta_step trail the internal slice/mark update by one cycle
      theta_step <= adv & ~stall_now;
      dtheta     <= (state == ST_LOCKED && !stall_now) ? theta_calc : '0;

      if (accept)
        count <= PERIOD_W'(1);
      else if (count != MAX_P)
        count <= count + 1'b1;

      case (state)
        ST_UNLOCKED: begin
          if (accept) begin
            state      <= ST_ACQUIRE;
            stalled    <= 1'b0;
            mark       <= '0;
            offset_lat <= offset_in;
          end
        end
        ST_ACQUIRE, ST_LOCKED: begin
          if (accept) begin
            state      <= ST_LOCKED;
            locked     <= 1'b1;
            period_out <= count;
            mark       <= (state == ST_ACQUIRE) ? MARK_ONE : mark_inc;
            slice      <= '0;
            acc        <= '0;
            adv        <= 1'b1;
            offset_lat <= offset_in;
          end else if (stall_now) begin
            state   <= ST_UNLOCKED;
            locked  <= 1'b0;
            stalled <= 1'b1;
          end else if (state == ST_LOCKED && slice != SLICE_LAST) begin
            // last slice of the sector holds until the next mark
            if (acc_sum >= period_ext) begin
              acc   <= acc_sum - period_ext;
              slice <= slice + 1'b1;
              adv   <= 1'b1;
            end else begin
              acc <= acc_sum;
            end
          end
        end
        default: state <= ST_UNLOCKED;
      endcase
    end
  end

endmodule
